transport_rcv: RTL and testbench

- Receive-side transport layer; the inverse of the transmit packetizer.
- Accepts the fixed-size byte stream produced by the transmitter and parses the header byte of each packet.
- Delivers control packets as a single 16-bit word with a command code.
- Unpacks audio packets into 16-bit samples queued in an internal FIFO for the audio consumer.
- Sits between the link/physical receive logic and the call-control and audio-playback blocks.

---
 rtl/transport_rcv_pkg.sv | 37 +++
 rtl/transport_rcv_sample_fifo.sv | 60 ++++++
 rtl/transport_rcv.sv | 129 ++++++++++++
 tb/tb_transport_rcv.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/transport_rcv_pkg.sv
// ============================================================================
// transport_rcv_pkg : header constants, command codes and parser state encoding
// Revision 1.0
// ============================================================================
`default_nettype none

package transport_rcv_pkg;

  localparam logic [7:0] HDR_CTRL  = 8'h40;
  localparam logic [7:0] HDR_AUDIO = 8'h80;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_CTRL  = 2'b01;
  localparam logic [1:0] CMD_AUDIO = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CTRL_HI = 3'd1,
    CTRL_LO = 3'd2,
    PAD     = 3'd3,
    AUD_HI  = 3'd4,
    AUD_LO  = 3'd5,
    DROP    = 3'd6
  } state_t;

  // Parser state entered after accepting a header byte.
  function automatic state_t hdrState(input logic [7:0] hdr);
    case (hdr)
      HDR_CTRL:  return CTRL_HI;
      HDR_AUDIO: return AUD_HI;
      default:   return DROP;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/transport_rcv_sample_fifo.sv
// ============================================================================
// sample_fifo : synchronous show-ahead FIFO with occupancy count
// Revision 1.0
// ============================================================================
`default_nettype none

module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wrEn,
  input  logic [WIDTH-1:0]         wrData,
  input  logic                     rdEn,
  output logic [WIDTH-1:0]         rdData,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wrPtr, r_rdPtr;
  logic [c_aw:0]    r_count;
  logic             w_rd, w_wr;

  // A read in the same cycle frees a slot, so a write into a full FIFO is kept.
  assign w_rd = rdEn && (r_count != '0);
  assign w_wr = wrEn && (!full || w_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wrPtr <= r_wrPtr + c_aw'(1);
      if (w_rd) r_rdPtr <= r_rdPtr + c_aw'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (c_aw+1)'(1);
        2'b01:   r_count <= r_count - (c_aw+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wrPtr] <= wrData;
  end

  assign empty  = (r_count == '0);
  assign full   = (r_count == (c_aw+1)'(DEPTH));
  assign count  = r_count;
  assign rdData = empty ? '0 : r_mem[r_rdPtr];

endmodule

`default_nettype wire

// File: rtl/transport_rcv.sv
// ============================================================================
// transport_rcv : parses received packets into control words and audio samples
// Revision 1.0
// ============================================================================
`default_nettype none

module transport_rcv
  import transport_rcv_pkg::*;
#(
  parameter int packetSize = 16,
  parameter int audioDepth = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    packetIn,
  input  logic                          byteValid,
  input  logic                          frameStart,
  output logic [1:0]                    cmdOut,
  output logic [15:0]                   ctrlData,
  output logic                          ctrlValid,
  input  logic                          audioRdEn,
  output logic [15:0]                   audioOut,
  output logic                          audioEmpty,
  output logic [$clog2(audioDepth):0]   audioCount,
  output logic                          busy,
  output logic                          pktErr,
  output logic                          overflow
);

  localparam logic [7:0] c_lastIdx = 8'(packetSize - 1);

  state_t      r_state, w_nextState;
  logic [7:0]  r_cnt, w_nextCnt;
  logic [7:0]  r_hi;
  logic [1:0]  r_cmd;
  logic [15:0] r_ctrlData;
  logic        r_ctrlValid, r_pktErr, r_overflow;
  logic        w_last, w_latchHi, w_ctrlFire, w_audWr, w_err, w_fifoFull;

  assign w_last = (r_cnt == c_lastIdx);

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_latchHi   = 1'b0;
    w_ctrlFire  = 1'b0;
    w_audWr     = 1'b0;
    w_err       = 1'b0;
    if (byteValid) begin
      if (frameStart) begin
        // A header always restarts parsing; any packet in flight is abandoned.
        w_nextState = hdrState(packetIn);
        w_nextCnt   = 8'd1;
        w_err       = (r_state != IDLE) || (hdrState(packetIn) == DROP);
      end else if (r_state != IDLE) begin
        w_nextCnt = w_last ? 8'd0 : r_cnt + 8'd1;
        case (r_state)
          CTRL_HI: begin
            w_latchHi   = 1'b1;
            w_nextState = w_last ? IDLE : CTRL_LO;
          end
          CTRL_LO: begin
            w_ctrlFire  = 1'b1;
            w_nextState = w_last ? IDLE : PAD;
          end
          AUD_HI: begin
            w_latchHi   = 1'b1;
            w_nextState = w_last ? IDLE : AUD_LO;
          end
          AUD_LO: begin
            w_audWr     = 1'b1;
            w_nextState = w_last ? IDLE : AUD_HI;
          end
          default: w_nextState = w_last ? IDLE : r_state;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_hi        <= 8'd0;
      r_cmd       <= CMD_IDLE;
      r_ctrlData  <= 16'd0;
      r_ctrlValid <= 1'b0;
      r_pktErr    <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_cnt       <= w_nextCnt;
      r_ctrlValid <= w_ctrlFire;
      r_pktErr    <= w_err;
      if (w_latchHi) r_hi <= packetIn;
      if (w_ctrlFire) begin
        r_ctrlData <= {r_hi, packetIn};
        r_cmd      <= CMD_CTRL;
      end
      if (w_audWr) r_cmd <= CMD_AUDIO;
      if (w_audWr && w_fifoFull && !audioRdEn) r_overflow <= 1'b1;
    end
  end

  sample_fifo #(
    .WIDTH (16),
    .DEPTH (audioDepth)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wrEn   (w_audWr),
    .wrData ({r_hi, packetIn}),
    .rdEn   (audioRdEn),
    .rdData (audioOut),
    .empty  (audioEmpty),
    .full   (w_fifoFull),
    .count  (audioCount)
  );

  assign busy      = (r_state != IDLE);
  assign cmdOut    = r_cmd;
  assign ctrlData  = r_ctrlData;
  assign ctrlValid = r_ctrlValid;
  assign pktErr    = r_pktErr;
  assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_transport_rcv.sv
// ============================================================================
// tb_transport_rcv : directed scoreboard bench for transport_rcv
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_transport_rcv;
  import transport_rcv_pkg::*;

  localparam int PKT   = 16;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset, byteValid, frameStart, audioRdEn;
  logic [7:0]  packetIn;
  logic [1:0]  cmdOut;
  logic [15:0] ctrlData, audioOut;
  logic        ctrlValid, audioEmpty, busy, pktErr, overflow;
  logic [6:0]  audioCount;

  transport_rcv #(.packetSize(PKT), .audioDepth(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .packetIn   (packetIn),
    .byteValid  (byteValid),
    .frameStart (frameStart),
    .cmdOut     (cmdOut),
    .ctrlData   (ctrlData),
    .ctrlValid  (ctrlValid),
    .audioRdEn  (audioRdEn),
    .audioOut   (audioOut),
    .audioEmpty (audioEmpty),
    .audioCount (audioCount),
    .busy       (busy),
    .pktErr     (pktErr),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int          nCmp = 0, nBad = 0;
  int          nCtrlSeen = 0, nErrSeen = 0, mCount = 0;
  logic        mOvf = 1'b0;
  logic [15:0] ctrlQ[$];
  logic [15:0] audQ[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    if (ctrlValid === 1'b1) begin
      nCtrlSeen++;
      chk("ctrl_expected", 32'(ctrlQ.size() != 0), 32'd1);
      if (ctrlQ.size() != 0)
        chk("ctrl_word", {14'd0, cmdOut, ctrlData}, {14'd0, CMD_CTRL, ctrlQ.pop_front()});
    end
    if (pktErr === 1'b1) nErrSeen++;
  endtask

  task automatic drive(input logic v, input logic fs, input logic [7:0] b, input logic rd);
    byteValid  = v;
    frameStart = fs;
    packetIn   = b;
    audioRdEn  = rd;
    @(posedge clk);
    #1;
    byteValid  = 1'b0;
    frameStart = 1'b0;
    audioRdEn  = 1'b0;
    observe();
  endtask

  // Audio packet whose payload byte i is seed + 0x11*i; optional pop at payload index rdAt.
  task automatic sendAudio(input logic [7:0] seed, input int rdAt);
    logic [7:0] hi, b;
    logic       rd;
    hi = 8'd0;
    drive(1'b1, 1'b1, HDR_AUDIO, 1'b0);
    for (int i = 0; i < PKT - 1; i++) begin
      b  = seed + 8'(i) * 8'h11;
      rd = (i == rdAt);
      if (rd) begin
        chk("audio_head_on_pop", 32'(audioOut), 32'(audQ[0]));
        void'(audQ.pop_front());
        mCount--;
      end
      if (i % 2 == 1) begin
        if (mCount < DEPTH) begin
          audQ.push_back({hi, b});
          mCount++;
        end else begin
          mOvf = 1'b1;
        end
      end else begin
        hi = b;
      end
      drive(1'b1, 1'b0, b, rd);
    end
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      chk("audio_sample", 32'(audioOut), 32'(audQ.pop_front()));
      mCount--;
      drive(1'b0, 1'b0, 8'h00, 1'b1);
    end
  endtask

  int errBase, ctrlBase, nLow;

  initial begin
    reset = 1'b1; byteValid = 1'b0; frameStart = 1'b0; audioRdEn = 1'b0; packetIn = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_audioEmpty", 32'(audioEmpty), 32'd1);
    chk("rst_audioCount", 32'(audioCount), 32'd0);
    chk("rst_audioOut",   32'(audioOut),   32'd0);
    chk("rst_ctrlValid",  32'(ctrlValid),  32'd0);
    chk("rst_ctrlData",   32'(ctrlData),   32'd0);
    chk("rst_cmdOut",     32'(cmdOut),     32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_pktErr",     32'(pktErr),     32'd0);
    chk("rst_overflow",   32'(overflow),   32'd0);
    reset = 1'b0;
    drive(1'b1, 1'b0, 8'h40, 1'b0);
    chk("idle_ignores_unframed", 32'(busy), 32'd0);

    // Control packet 40 12 34 + 13 pad bytes
    ctrlQ.push_back(16'h1234);
    drive(1'b1, 1'b1, 8'h40, 1'b0);
    chk("ctrl_busy_after_hdr", 32'(busy), 32'd1);
    drive(1'b1, 1'b0, 8'h12, 1'b0);
    chk("ctrl_no_early_pulse", 32'(ctrlValid), 32'd0);
    drive(1'b1, 1'b0, 8'h34, 1'b0);
    chk("ctrl_pulse", 32'(ctrlValid), 32'd1);
    chk("ctrl_data",  32'(ctrlData),  32'h1234);
    chk("ctrl_cmd",   32'(cmdOut),    32'd1);
    for (int i = 0; i < PKT - 3; i++) begin
      drive(1'b1, 1'b0, 8'h80 ^ 8'(i), 1'b0);
      if (i == 0) chk("ctrl_pulse_one_cycle", 32'(ctrlValid), 32'd0);
      if (i == PKT - 5) chk("ctrl_busy_before_last", 32'(busy), 32'd1);
    end
    chk("ctrl_busy_end", 32'(busy), 32'd0);
    chk("ctrl_pulse_count", 32'(nCtrlSeen), 32'd1);

    // Audio packet 80 AA BB CC ...
    sendAudio(8'hAA, -1);
    chk("aud_count", 32'(audioCount), 32'd7);
    chk("aud_head",  32'(audioOut),   32'hAABB);
    chk("aud_cmd",   32'(cmdOut),     32'd2);
    chk("aud_no_err", 32'(nErrSeen),  32'd0);
    chk("aud_busy_end", 32'(busy),    32'd0);
    drain(7);
    chk("aud_empty_after_drain", 32'(audioEmpty), 32'd1);

    // Bad header 0x55 + 15 bytes
    ctrlBase = nCtrlSeen;
    drive(1'b1, 1'b1, 8'h55, 1'b0);
    chk("bad_hdr_err", 32'(pktErr), 32'd1);
    nLow = 0;
    for (int i = 0; i < PKT - 1; i++) begin
      drive(1'b1, 1'b0, 8'(i) + 8'h40, 1'b0);
      if (i < PKT - 2 && busy !== 1'b1) nLow++;
    end
    chk("bad_busy_held", 32'(nLow), 32'd0);
    chk("bad_busy_end", 32'(busy), 32'd0);
    chk("bad_err_count", 32'(nErrSeen), 32'd1);
    chk("bad_no_ctrl", 32'(nCtrlSeen), 32'(ctrlBase));
    chk("bad_no_audio", 32'(audioCount), 32'd0);

    // Abort: audio packet interrupted by a control header
    errBase = nErrSeen;
    drive(1'b1, 1'b1, HDR_AUDIO, 1'b0);
    drive(1'b1, 1'b0, 8'hAA, 1'b0);
    drive(1'b1, 1'b0, 8'hBB, 1'b0);
    drive(1'b1, 1'b0, 8'hCC, 1'b0);
    drive(1'b1, 1'b0, 8'hDD, 1'b0);
    drive(1'b1, 1'b0, 8'hEE, 1'b0);
    audQ.push_back(16'hAABB); audQ.push_back(16'hCCDD); mCount += 2;
    ctrlQ.push_back(16'h5678);
    drive(1'b1, 1'b1, HDR_CTRL, 1'b0);
    chk("abort_err", 32'(pktErr), 32'd1);
    drive(1'b1, 1'b0, 8'h56, 1'b0);
    chk("abort_err_pulse", 32'(pktErr), 32'd0);
    drive(1'b1, 1'b0, 8'h78, 1'b0);
    for (int i = 0; i < PKT - 3; i++) drive(1'b1, 1'b0, 8'h11, 1'b0);
    chk("abort_err_count", 32'(nErrSeen), 32'(errBase + 1));
    chk("abort_ctrl_count", 32'(nCtrlSeen), 32'(ctrlBase + 1));
    chk("abort_kept", 32'(audioCount), 32'd2);
    drain(2);

    // Fill to 63, then overflow, then concurrent pop on a full FIFO
    for (int p = 0; p < 9; p++) sendAudio(8'(p * 7), -1);
    chk("fill_count_63", 32'(audioCount), 32'd63);
    chk("fill_no_overflow", 32'(overflow), 32'd0);
    sendAudio(8'h3C, -1);
    chk("ovf_count", 32'(audioCount), 32'd64);
    chk("ovf_flag", 32'(overflow), 32'(mOvf));
    sendAudio(8'h5A, 1);
    chk("full_rdwr_count", 32'(audioCount), 32'(mCount));
    drain(DEPTH);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("drain_empty", 32'(audioEmpty), 32'd1);

    // Reset while in CTRL_LO
    ctrlBase = nCtrlSeen;
    sendAudio(8'h21, -1);
    drive(1'b1, 1'b1, HDR_CTRL, 1'b0);
    drive(1'b1, 1'b0, 8'h9A, 1'b0);
    reset = 1'b1; byteValid = 1'b1; packetIn = 8'hBC;
    @(posedge clk);
    #1;
    reset = 1'b0; byteValid = 1'b0;
    audQ.delete(); mCount = 0;
    chk("mid_rst_ctrlValid", 32'(ctrlValid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(audioCount), 32'd0);
    chk("mid_rst_audioOut", 32'(audioOut), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_cmd", 32'(cmdOut), 32'd0);
    chk("mid_rst_ctrlData", 32'(ctrlData), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("mid_rst_no_pulse", 32'(nCtrlSeen), 32'(ctrlBase));
    chk("ctrlq_drained", 32'(ctrlQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

`default_nettype wire
